dm_arbiter: RTL

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// Shares one data-memory port between the CPU MEM stage and a debug/loader port.
// The CPU wins contention until the debug side has lost DBG_WAIT_MAX cycles, then one slot is forced.
module dm_arbiter #(
  parameter int unsigned DBG_WAIT_MAX = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CPU_MEMREAD,
  input  logic        CPU_MEMWRITE,
  input  logic [63:0] CPU_ADDRESS,
  input  logic [63:0] CPU_WRITE_DATA,
  output logic [63:0] CPU_READ_DATA,
  output logic        CPU_STALL,
  input  logic        DBG_REQ,
  input  logic        DBG_WE,
  input  logic [63:0] DBG_ADDRESS,
  input  logic [63:0] DBG_WDATA,
  output logic [63:0] DBG_RDATA,
  output logic        DBG_ACK,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [63:0] ADDRESS,
  output logic [63:0] WRITE_DATA,
  input  logic [63:0] READ_DATA
);

  typedef enum logic [1:0] {IDLE, WAIT, FORCE, ACK} state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(DBG_WAIT_MAX);

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next, cnt_inc;
  logic       cpu_req;
  logic       dbg_slot;

  assign cpu_req       = CPU_MEMREAD | CPU_MEMWRITE;
  assign cnt_inc       = cnt + 8'd1;
  assign CPU_READ_DATA = READ_DATA;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      DBG_ACK   <= 1'b0;
      DBG_RDATA <= 64'd0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      DBG_ACK <= (state_next == ACK);
      if (dbg_slot && !DBG_WE)
        DBG_RDATA <= READ_DATA;
    end
  end

  // cnt counts cycles the CPU won while debug was waiting; reaching the limit forces a slot
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    dbg_slot   = 1'b0;
    case (state)
      IDLE: begin
        if (DBG_REQ && !cpu_req) begin
          dbg_slot   = 1'b1;
          state_next = ACK;
        end else if (DBG_REQ) begin
          cnt_next   = cnt_inc;
          state_next = (cnt_inc == WAIT_LIMIT) ? FORCE : WAIT;
        end
      end
      WAIT: begin
        if (!DBG_REQ) begin
          cnt_next   = 8'd0;
          state_next = IDLE;
        end else if (!cpu_req) begin
          dbg_slot   = 1'b1;
          state_next = ACK;
        end else begin
          cnt_next   = cnt_inc;
          state_next = (cnt_inc == WAIT_LIMIT) ? FORCE : WAIT;
        end
      end
      FORCE: begin
        dbg_slot   = 1'b1;
        state_next = ACK;
      end
      ACK: begin
        cnt_next   = 8'd0;
        state_next = IDLE;
      end
      default: begin
        cnt_next   = 8'd0;
        state_next = IDLE;
      end
    endcase
  end

  // A debug slot with the CPU requesting only happens in FORCE, so that is the stall case
  always_comb begin
    ADDRESS    = CPU_ADDRESS;
    WRITE_DATA = CPU_WRITE_DATA;
    MEM_READ   = CPU_MEMREAD & ~RST;
    MEM_WRITE  = CPU_MEMWRITE & ~RST;
    CPU_STALL  = 1'b0;
    if (dbg_slot && !RST) begin
      ADDRESS    = DBG_ADDRESS;
      WRITE_DATA = DBG_WDATA;
      MEM_READ   = ~DBG_WE;
      MEM_WRITE  = DBG_WE;
      CPU_STALL  = cpu_req;
    end
  end

endmodule
